// File: rtl/regfile_sb_if.sv
// Decode/issue and write-back bus for the scoreboarded register file.
// The master side is the pipeline; the slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);
  localparam int NB = WIDTH / 8;

  logic             WE;
  logic [AW-1:0]    DR;
  logic [NB-1:0]    BE;
  logic [WIDTH-1:0] bus;
  logic [AW-1:0]    SR1;
  logic [AW-1:0]    SR2;
  logic [WIDTH-1:0] RA;
  logic [WIDTH-1:0] RB;
  logic             busy_a;
  logic             busy_b;
  logic             issue_valid;
  logic [AW-1:0]    issue_dr;
  logic             issue_ready;
  logic             flush;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output WE, DR, BE, bus, SR1, SR2, issue_valid, issue_dr, flush,
    input  RA, RB, busy_a, busy_b, issue_ready, busy_vec
  );

  modport slave (
    input  WE, DR, BE, bus, SR1, SR2, issue_valid, issue_dr, flush,
    output RA, RB, busy_a, busy_b, issue_ready, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with byte-strobed write port, write-through
// bypass on both read ports, and a per-register write-pending scoreboard.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          reset,
  regfile_sb_if.slave   rf
);
  localparam int AW = $clog2(NREGS);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_hit_a;
  logic             w_hit_b;
  logic             w_hit_issue;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int unsigned k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

  assign w_hit_a     = rf.WE & (rf.DR == rf.SR1);
  assign w_hit_b     = rf.WE & (rf.DR == rf.SR2);
  assign w_hit_issue = rf.WE & (rf.DR == rf.issue_dr);

  // Bypass is masked while reset is low so the read ports show the cleared array.
  assign rf.RA = (w_hit_a & reset) ? merge(r_regs[rf.SR1], rf.bus, rf.BE) : r_regs[rf.SR1];
  assign rf.RB = (w_hit_b & reset) ? merge(r_regs[rf.SR2], rf.bus, rf.BE) : r_regs[rf.SR2];

  assign rf.busy_a      = r_busy[rf.SR1] & ~w_hit_a;
  assign rf.busy_b      = r_busy[rf.SR2] & ~w_hit_b;
  assign rf.issue_ready = ~r_busy[rf.issue_dr] | w_hit_issue;
  assign rf.busy_vec    = r_busy;
  assign w_accept       = rf.issue_valid & rf.issue_ready;

  // Later assignments win: retire, then new reservation, then flush.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf.WE)    w_busy_nxt[rf.DR]       = 1'b0;
    if (w_accept) w_busy_nxt[rf.issue_dr] = 1'b1;
    if (rf.flush) w_busy_nxt              = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (rf.WE) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (rf.BE[k]) r_regs[rf.DR][8*k +: 8] <= rf.bus[8*k +: 8];
        end
      end
    end
  end
endmodule
